// File: rtl/dlx_pkg.sv
// Shared definitions for the DLX control FSM: state encoding, control-word
// bit map, opcode fields and small decode helpers.
package dlx_pkg;

  typedef enum logic [4:0] {
    S_INIT        = 5'd0,
    S_FETCH       = 5'd1,
    S_DECODE      = 5'd2,
    S_ALU         = 5'd3,
    S_SHIFT       = 5'd4,
    S_WBR         = 5'd5,
    S_ALUI        = 5'd6,
    S_TESTI       = 5'd7,
    S_WBI         = 5'd8,
    S_ADDRCMP     = 5'd9,
    S_LOAD        = 5'd10,
    S_COPYMDR2C   = 5'd11,
    S_COPYGPR2MDR = 5'd12,
    S_STORE       = 5'd13,
    S_JR          = 5'd14,
    S_SAVEPC      = 5'd15,
    S_JALR        = 5'd16,
    S_BRANCH      = 5'd17,
    S_BTAKEN      = 5'd18,
    S_HALT        = 5'd19,
    S_BUSERR      = 5'd20
  } state_t;

  localparam int CTRL_W = 22;

  // Ace and Bce are always asserted together, so they share one wire.
  localparam int CTRL_MR         = 0;
  localparam int CTRL_MW         = 1;
  localparam int CTRL_IRCE       = 2;
  localparam int CTRL_ACE        = 3;
  localparam int CTRL_BCE        = 3;
  localparam int CTRL_PCCE       = 4;
  localparam int CTRL_GPR_WE     = 5;
  localparam int CTRL_CCE        = 6;
  localparam int CTRL_MARCE      = 7;
  localparam int CTRL_MDRCE      = 8;
  localparam int CTRL_MDRSEL     = 9;
  localparam int CTRL_ASEL       = 10;
  localparam int CTRL_SHIFTEN    = 11;
  localparam int CTRL_JLINK      = 12;
  localparam int CTRL_TEST       = 13;
  localparam int CTRL_ITYPE      = 14;
  localparam int CTRL_ADD        = 15;
  localparam int CTRL_DINTSEL    = 16;
  localparam int CTRL_S1SEL0     = 17;
  localparam int CTRL_S1SEL1     = 18;
  localparam int CTRL_S2SEL0     = 19;
  localparam int CTRL_S2SEL1     = 20;
  localparam int CTRL_SHIFTRIGHT = 21;

  localparam logic [2:0] OPC3_END    = 3'b110;
  localparam logic [2:0] OPC3_ALUI   = 3'b001;
  localparam logic [2:0] OPC3_TESTI  = 3'b011;
  localparam logic [2:0] OPC3_JUMP   = 3'b010;
  localparam logic [3:0] OPC4_RTYPE  = 4'b0000;
  localparam logic [3:0] OPC4_BRANCH = 4'b0001;
  localparam logic [1:0] OPC2_MEM    = 2'b10;

  localparam int IR_ALU_BIT   = 5;
  localparam int IR_STORE_BIT = 29;
  localparam int IR_SEL_BIT   = 26;
  localparam int IR_SHR_BIT   = 1;

  function automatic logic is_wait_state(input state_t s);
    return (s == S_FETCH) || (s == S_LOAD) || (s == S_STORE);
  endfunction

  // Memory handshake states hold on busy and trap once the timer has expired.
  function automatic state_t wait_next(input logic busy, input logic expired,
                                       input state_t hold, input state_t adv);
    state_t r;
    if (busy) begin
      if (expired) begin
        r = S_BUSERR;
      end else begin
        r = hold;
      end
    end else begin
      r = adv;
    end
    return r;
  endfunction

endpackage

// File: rtl/dlx_busy_timer.sv
// Saturating-limit counter of consecutive memory-busy cycles; expired flags
// that the all-ones limit has been reached.
module dlx_busy_timer #(
  parameter int TMO_W = 4
) (
  input  logic clk,
  input  logic reset,
  input  logic clr,
  input  logic cnt,
  output logic expired
);

  logic [TMO_W-1:0] count_r;

  // busy-cycle counter, cleared whenever the FSM changes state
  always_ff @(posedge clk) begin
    if (reset) begin
      count_r <= '0;
    end else if (clr) begin
      count_r <= '0;
    end else if (cnt) begin
      count_r <= count_r + TMO_W'(1);
    end else begin
      count_r <= count_r;
    end
  end

  assign expired = (count_r == {TMO_W{1'b1}});

endmodule

// File: rtl/dlx_ctrl.sv
// Multicycle DLX control FSM: sequences fetch/decode/execute, decodes the
// datapath control word from state, and tracks bus timeouts and retirements.
module dlx_ctrl import dlx_pkg::*; #(
  parameter int TMO_W        = 4,
  parameter int CNT_W        = 16,
  parameter bit STORE_RESUME = 1'b1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              step_en,
  input  logic              run_en,
  input  logic              busy,
  input  logic [31:0]       IR,
  input  logic              AEQZ,
  output logic [4:0]        state,
  output logic [21:0]       ctrl,
  output logic              IN_INIT,
  output logic              bus_err,
  output logic [CNT_W-1:0]  instret
);

  state_t             state_r, next_s, end_s;
  logic               go_s, retire_s, tmo_clr_s, tmo_cnt_s, tmo_expired_s;
  logic               bus_err_r;
  logic [CNT_W-1:0]   instret_r;
  logic [CTRL_W-1:0]  ctrl_s;

  assign go_s  = step_en | run_en;
  assign end_s = go_s ? S_FETCH : S_INIT;

  // the single state register
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r <= S_INIT;
    end else begin
      state_r <= next_s;
    end
  end

  // next-state and retirement decode
  always_comb begin
    next_s   = S_INIT;
    retire_s = 1'b0;
    case (state_r)
      S_INIT:        next_s = go_s ? S_FETCH : S_INIT;
      S_FETCH:       next_s = wait_next(busy, tmo_expired_s, S_FETCH, S_DECODE);
      S_DECODE: begin
        if (IR[31:29] == OPC3_END) begin
          next_s   = end_s;
          retire_s = 1'b1;
        end else if (IR[31:28] == OPC4_RTYPE) begin
          next_s = IR[IR_ALU_BIT] ? S_ALU : S_SHIFT;
        end else if (IR[31:29] == OPC3_ALUI) begin
          next_s = S_ALUI;
        end else if (IR[31:29] == OPC3_TESTI) begin
          next_s = S_TESTI;
        end else if (IR[31:30] == OPC2_MEM) begin
          next_s = S_ADDRCMP;
        end else if (IR[31:29] == OPC3_JUMP) begin
          next_s = IR[IR_SEL_BIT] ? S_SAVEPC : S_JR;
        end else if (IR[31:28] == OPC4_BRANCH) begin
          next_s = S_BRANCH;
        end else begin
          next_s = S_HALT;
        end
      end
      S_ALU, S_SHIFT:  next_s = S_WBR;
      S_ALUI, S_TESTI: next_s = S_WBI;
      S_ADDRCMP:       next_s = IR[IR_STORE_BIT] ? S_COPYGPR2MDR : S_LOAD;
      S_LOAD:          next_s = wait_next(busy, tmo_expired_s, S_LOAD, S_COPYMDR2C);
      S_COPYMDR2C:     next_s = S_WBI;
      S_COPYGPR2MDR:   next_s = S_STORE;
      S_STORE: begin
        next_s = wait_next(busy, tmo_expired_s, S_STORE,
                           (STORE_RESUME && go_s) ? S_FETCH : S_INIT);
        retire_s = ~busy;
      end
      S_SAVEPC:        next_s = S_JALR;
      S_BRANCH: begin
        if (AEQZ ^ IR[IR_SEL_BIT]) begin
          next_s = S_BTAKEN;
        end else begin
          next_s   = end_s;
          retire_s = 1'b1;
        end
      end
      S_WBR, S_WBI, S_JR, S_JALR, S_BTAKEN: begin
        next_s   = end_s;
        retire_s = 1'b1;
      end
      S_HALT:          next_s = S_HALT;
      S_BUSERR:        next_s = S_BUSERR;
      default:         next_s = S_INIT;
    endcase
  end

  assign tmo_clr_s = (next_s != state_r);
  assign tmo_cnt_s = busy & is_wait_state(state_r);

  dlx_busy_timer #(.TMO_W(TMO_W)) u_busy_timer (
    .clk     (clk),
    .reset   (reset),
    .clr     (tmo_clr_s),
    .cnt     (tmo_cnt_s),
    .expired (tmo_expired_s)
  );

  // control word decode from the current state
  always_comb begin
    ctrl_s = '0;
    case (state_r)
      S_FETCH:       begin ctrl_s[CTRL_MR] = 1'b1; ctrl_s[CTRL_IRCE] = 1'b1; end
      S_DECODE: begin
        ctrl_s[CTRL_ACE] = 1'b1;  ctrl_s[CTRL_BCE] = 1'b1;    ctrl_s[CTRL_PCCE] = 1'b1;
        ctrl_s[CTRL_ADD] = 1'b1;  ctrl_s[CTRL_S2SEL0] = 1'b1; ctrl_s[CTRL_S2SEL1] = 1'b1;
      end
      S_ALU:         begin ctrl_s[CTRL_CCE] = 1'b1; ctrl_s[CTRL_S1SEL0] = 1'b1; end
      S_SHIFT: begin
        ctrl_s[CTRL_CCE] = 1'b1;     ctrl_s[CTRL_SHIFTEN] = 1'b1; ctrl_s[CTRL_DINTSEL] = 1'b1;
        ctrl_s[CTRL_S1SEL0] = 1'b1;  ctrl_s[CTRL_SHIFTRIGHT] = IR[IR_SHR_BIT];
      end
      S_WBR:         ctrl_s[CTRL_GPR_WE] = 1'b1;
      S_ALUI: begin
        ctrl_s[CTRL_CCE] = 1'b1;    ctrl_s[CTRL_ITYPE] = 1'b1;  ctrl_s[CTRL_ADD] = 1'b1;
        ctrl_s[CTRL_S1SEL0] = 1'b1; ctrl_s[CTRL_S2SEL0] = 1'b1;
      end
      S_TESTI: begin
        ctrl_s[CTRL_CCE] = 1'b1;    ctrl_s[CTRL_TEST] = 1'b1;   ctrl_s[CTRL_ITYPE] = 1'b1;
        ctrl_s[CTRL_S1SEL0] = 1'b1; ctrl_s[CTRL_S2SEL0] = 1'b1;
      end
      S_WBI:         begin ctrl_s[CTRL_GPR_WE] = 1'b1; ctrl_s[CTRL_ITYPE] = 1'b1; end
      S_ADDRCMP: begin
        ctrl_s[CTRL_MARCE] = 1'b1;  ctrl_s[CTRL_ADD] = 1'b1;
        ctrl_s[CTRL_S1SEL0] = 1'b1; ctrl_s[CTRL_S2SEL0] = 1'b1;
      end
      S_LOAD: begin
        ctrl_s[CTRL_MR] = 1'b1;     ctrl_s[CTRL_MDRCE] = 1'b1;
        ctrl_s[CTRL_MDRSEL] = 1'b1; ctrl_s[CTRL_ASEL] = 1'b1;
      end
      S_COPYMDR2C: begin
        ctrl_s[CTRL_CCE] = 1'b1;    ctrl_s[CTRL_DINTSEL] = 1'b1; ctrl_s[CTRL_S1SEL0] = 1'b1;
        ctrl_s[CTRL_S1SEL1] = 1'b1; ctrl_s[CTRL_S2SEL1] = 1'b1;
      end
      S_COPYGPR2MDR: begin
        ctrl_s[CTRL_MDRCE] = 1'b1;  ctrl_s[CTRL_DINTSEL] = 1'b1;
        ctrl_s[CTRL_S1SEL1] = 1'b1; ctrl_s[CTRL_S2SEL1] = 1'b1;
      end
      S_STORE:       begin ctrl_s[CTRL_MW] = 1'b1; ctrl_s[CTRL_ASEL] = 1'b1; end
      S_JR: begin
        ctrl_s[CTRL_PCCE] = 1'b1;   ctrl_s[CTRL_ADD] = 1'b1;
        ctrl_s[CTRL_S1SEL0] = 1'b1; ctrl_s[CTRL_S2SEL1] = 1'b1;
      end
      S_SAVEPC:      begin ctrl_s[CTRL_CCE] = 1'b1; ctrl_s[CTRL_ADD] = 1'b1; ctrl_s[CTRL_S2SEL1] = 1'b1; end
      S_JALR: begin
        ctrl_s[CTRL_PCCE] = 1'b1;   ctrl_s[CTRL_GPR_WE] = 1'b1; ctrl_s[CTRL_JLINK] = 1'b1;
        ctrl_s[CTRL_ADD] = 1'b1;    ctrl_s[CTRL_S1SEL0] = 1'b1; ctrl_s[CTRL_S2SEL1] = 1'b1;
      end
      S_BTAKEN:      begin ctrl_s[CTRL_PCCE] = 1'b1; ctrl_s[CTRL_ADD] = 1'b1; ctrl_s[CTRL_S2SEL0] = 1'b1; end
      default:       ctrl_s = '0;
    endcase
  end

  // sticky bus error and retired-instruction counter
  always_ff @(posedge clk) begin
    if (reset) begin
      bus_err_r <= 1'b0;
      instret_r <= '0;
    end else begin
      bus_err_r <= bus_err_r | (next_s == S_BUSERR);
      if (retire_s) begin
        instret_r <= instret_r + CNT_W'(1);
      end else begin
        instret_r <= instret_r;
      end
    end
  end

  assign state   = state_r;
  assign ctrl    = ctrl_s;
  assign IN_INIT = (state_r == S_INIT) || (state_r == S_HALT) || (state_r == S_BUSERR);
  assign bus_err = bus_err_r;
  assign instret = instret_r;

endmodule

// File: tb/tb_dlx_ctrl.sv
// Self-checking bench for dlx_ctrl: two configurations driven in lockstep,
// directed scenarios followed by randomized stimulus against a reference model.
module tb_dlx_ctrl;
  import dlx_pkg::CTRL_W;
  import dlx_pkg::CTRL_MR;     import dlx_pkg::CTRL_MW;      import dlx_pkg::CTRL_IRCE;
  import dlx_pkg::CTRL_ACE;    import dlx_pkg::CTRL_PCCE;    import dlx_pkg::CTRL_GPR_WE;
  import dlx_pkg::CTRL_CCE;    import dlx_pkg::CTRL_MARCE;   import dlx_pkg::CTRL_MDRCE;
  import dlx_pkg::CTRL_MDRSEL; import dlx_pkg::CTRL_ASEL;    import dlx_pkg::CTRL_SHIFTEN;
  import dlx_pkg::CTRL_JLINK;  import dlx_pkg::CTRL_TEST;    import dlx_pkg::CTRL_ITYPE;
  import dlx_pkg::CTRL_ADD;    import dlx_pkg::CTRL_DINTSEL; import dlx_pkg::CTRL_S1SEL0;
  import dlx_pkg::CTRL_S1SEL1; import dlx_pkg::CTRL_S2SEL0;  import dlx_pkg::CTRL_S2SEL1;
  import dlx_pkg::CTRL_SHIFTRIGHT;

  logic        clk = 1'b0;
  logic        reset = 1'b1, step_en = 1'b0, run_en = 1'b0, busy = 1'b0, AEQZ = 1'b0;
  logic [31:0] IR = 32'd0;

  logic [4:0]  state_a, state_b;
  logic [21:0] ctrl_a, ctrl_b;
  logic        in_init_a, in_init_b, bus_err_a, bus_err_b;
  logic [3:0]  instret_a;
  logic [15:0] instret_b;

  dlx_ctrl #(.TMO_W(2), .CNT_W(4), .STORE_RESUME(1'b1)) u_dut_a (
    .clk(clk), .reset(reset), .step_en(step_en), .run_en(run_en), .busy(busy),
    .IR(IR), .AEQZ(AEQZ), .state(state_a), .ctrl(ctrl_a), .IN_INIT(in_init_a),
    .bus_err(bus_err_a), .instret(instret_a));

  dlx_ctrl #(.TMO_W(4), .CNT_W(16), .STORE_RESUME(1'b0)) u_dut_b (
    .clk(clk), .reset(reset), .step_en(step_en), .run_en(run_en), .busy(busy),
    .IR(IR), .AEQZ(AEQZ), .state(state_b), .ctrl(ctrl_b), .IN_INIT(in_init_b),
    .bus_err(bus_err_b), .instret(instret_b));

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check_value(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Reference model, index 0 = config a, 1 = config b.
  int m_st[2]  = '{0, 0};
  int m_tmo[2] = '{0, 0};
  int m_ret[2] = '{0, 0};
  int m_err[2] = '{0, 0};
  int tmo_max[2] = '{3, 15};
  int cnt_mod[2] = '{16, 65536};
  int sres[2]    = '{1, 0};
  logic [31:0] ctrl_mask [CTRL_W];

  function automatic logic [31:0] st(input int n);
    return 32'd1 << n;
  endfunction

  function automatic int decode_target(input logic [31:0] ir, input int fin);
    if (ir[31:29] == 3'b110) return fin;
    if (ir[31:28] == 4'b0000) return ir[5] ? 3 : 4;
    if (ir[31:29] == 3'b001) return 6;
    if (ir[31:29] == 3'b011) return 7;
    if (ir[31:30] == 2'b10) return 9;
    if (ir[31:29] == 3'b010) return ir[26] ? 15 : 14;
    if (ir[31:28] == 4'b0001) return 17;
    return 19;
  endfunction

  function automatic int model_next(input int k);
    int s   = m_st[k];
    int fin = (step_en | run_en) ? 1 : 0;
    if ((s == 1 || s == 10 || s == 13) && busy)
      return (m_tmo[k] == tmo_max[k]) ? 20 : s;
    case (s)
      0:             return fin;
      1:             return 2;
      2:             return decode_target(IR, fin);
      3, 4:          return 5;
      6, 7:          return 8;
      9:             return IR[29] ? 12 : 10;
      10:            return 11;
      11:            return 8;
      12:            return 13;
      13:            return (sres[k] == 1 && fin == 1) ? 1 : 0;
      15:            return 16;
      17:            return (AEQZ ^ IR[26]) ? 18 : fin;
      5, 8, 14, 16, 18: return fin;
      19, 20:        return s;
      default:       return 0;
    endcase
  endfunction

  task automatic model_update();
    for (int k = 0; k < 2; k++) begin
      int s, ns;
      bit retire;
      s = m_st[k];
      if (reset) begin
        m_st[k] = 0; m_tmo[k] = 0; m_ret[k] = 0; m_err[k] = 0;
      end else begin
        ns = model_next(k);
        retire = (s == 5 || s == 8 || s == 14 || s == 16 || s == 18) ||
                 (s == 17 && ns != 18) || (s == 2 && ns <= 1) || (s == 13 && !busy);
        if (retire) m_ret[k] = (m_ret[k] + 1) % cnt_mod[k];
        if (ns == 20) m_err[k] = 1;
        if (ns != s) m_tmo[k] = 0;
        else if (busy && (s == 1 || s == 10 || s == 13)) m_tmo[k] = m_tmo[k] + 1;
        m_st[k] = ns;
      end
    end
  endtask

  function automatic logic [31:0] exp_ctrl(input int s);
    logic [31:0] e = 32'd0;
    for (int b = 0; b < CTRL_W; b++) e[b] = ctrl_mask[b][s];
    e[CTRL_SHIFTRIGHT] = (s == 4) && IR[1];
    return e;
  endfunction

  task automatic check_all();
    check_value("a.state", 32'(state_a), 32'(m_st[0]));
    check_value("a.ctrl", 32'(ctrl_a), exp_ctrl(m_st[0]));
    check_value("a.in_init", 32'(in_init_a), 32'(m_st[0] == 0 || m_st[0] >= 19));
    check_value("a.bus_err", 32'(bus_err_a), 32'(m_err[0]));
    check_value("a.instret", 32'(instret_a), 32'(m_ret[0]));
    check_value("b.state", 32'(state_b), 32'(m_st[1]));
    check_value("b.ctrl", 32'(ctrl_b), exp_ctrl(m_st[1]));
    check_value("b.in_init", 32'(in_init_b), 32'(m_st[1] == 0 || m_st[1] >= 19));
    check_value("b.bus_err", 32'(bus_err_b), 32'(m_err[1]));
    check_value("b.instret", 32'(instret_b), 32'(m_ret[1]));
  endtask

  task automatic tick(input logic r, input logic se, input logic re, input logic b,
                      input logic [31:0] ir, input logic z);
    reset = r; step_en = se; run_en = re; busy = b; IR = ir; AEQZ = z;
    @(posedge clk);
    model_update();
    #1;
    check_all();
  endtask

  task automatic go_tick(input logic [31:0] ir, input logic b, input logic z);
    tick(1'b0, 1'b0, 1'b1, b, ir, z);
  endtask

  task automatic rst_tick();
    tick(1'b1, 1'b0, 1'b0, 1'b0, 32'd0, 1'b0);
  endtask

  int add_seq[5] = '{1, 2, 3, 5, 1};
  int load_cycles;
  int burst;

  initial begin
    for (int b = 0; b < CTRL_W; b++) ctrl_mask[b] = 32'd0;
    ctrl_mask[CTRL_MR]      = st(1) | st(10);
    ctrl_mask[CTRL_MW]      = st(13);
    ctrl_mask[CTRL_IRCE]    = st(1);
    ctrl_mask[CTRL_ACE]     = st(2);
    ctrl_mask[CTRL_PCCE]    = st(2) | st(14) | st(16) | st(18);
    ctrl_mask[CTRL_GPR_WE]  = st(5) | st(8) | st(16);
    ctrl_mask[CTRL_CCE]     = st(3) | st(4) | st(6) | st(7) | st(15) | st(11);
    ctrl_mask[CTRL_MARCE]   = st(9);
    ctrl_mask[CTRL_MDRCE]   = st(10) | st(12);
    ctrl_mask[CTRL_MDRSEL]  = st(10);
    ctrl_mask[CTRL_ASEL]    = st(10) | st(13);
    ctrl_mask[CTRL_SHIFTEN] = st(4);
    ctrl_mask[CTRL_JLINK]   = st(16);
    ctrl_mask[CTRL_TEST]    = st(7);
    ctrl_mask[CTRL_ITYPE]   = st(6) | st(7) | st(8);
    ctrl_mask[CTRL_ADD]     = st(2) | st(6) | st(9) | st(14) | st(15) | st(16) | st(18);
    ctrl_mask[CTRL_DINTSEL] = st(4) | st(11) | st(12);
    ctrl_mask[CTRL_S1SEL0]  = st(3) | st(4) | st(6) | st(7) | st(9) | st(11) | st(14) | st(16);
    ctrl_mask[CTRL_S1SEL1]  = st(11) | st(12);
    ctrl_mask[CTRL_S2SEL0]  = st(2) | st(6) | st(7) | st(9) | st(18);
    ctrl_mask[CTRL_S2SEL1]  = st(2) | st(14) | st(15) | st(16) | st(11) | st(12);

    rst_tick(); rst_tick();
    check_value("reset.state", 32'(state_a), 32'd0);
    check_value("reset.ctrl", 32'(ctrl_a), 32'd0);

    // ADD: FETCH, DECODE, ALU, WBR, FETCH
    for (int i = 0; i < 5; i++) begin
      go_tick(32'h0000_0020, 1'b0, 1'b0);
      check_value("add.seq", 32'(state_a), 32'(add_seq[i]));
      check_value("add.gpr_we", 32'(ctrl_a[CTRL_GPR_WE]), 32'(add_seq[i] == 5));
    end
    check_value("add.instret", 32'(instret_a), 32'd1);

    // Load with busy held three cycles in LOAD
    rst_tick();
    load_cycles = 0;
    for (int i = 0; i < 9; i++) begin
      go_tick(32'h8000_0000, (i >= 4 && i <= 6), 1'b0);
      if (state_a == 5'd10) begin
        load_cycles++;
        check_value("load.mr", 32'(ctrl_a[CTRL_MR]), 32'd1);
      end
      if (i == 7) check_value("load.copy", 32'(state_a), 32'd11);
      if (i == 8) check_value("load.wbi", 32'(state_a), 32'd8);
    end
    check_value("load.cycles", 32'(load_cycles), 32'd4);

    // Busy stuck in FETCH with the 2-bit timer
    rst_tick();
    for (int i = 0; i < 5; i++) go_tick(32'h0000_0020, 1'b1, 1'b0);
    check_value("tmo.buserr", 32'(state_a), 32'd20);
    for (int i = 0; i < 3; i++) begin
      go_tick(32'h0000_0020, 1'b0, 1'b0);
      check_value("tmo.sticky", 32'(bus_err_a), 32'd1);
      check_value("tmo.ctrl", 32'(ctrl_a), 32'd0);
    end

    // BEQZ taken, then not taken
    rst_tick();
    for (int i = 0; i < 4; i++) go_tick(32'h1000_0000, 1'b0, 1'b1);
    check_value("beqz.btaken", 32'(state_a), 32'd18);
    check_value("beqz.pcce", 32'(ctrl_a[CTRL_PCCE]), 32'd1);
    for (int i = 0; i < 4; i++) go_tick(32'h1000_0000, 1'b0, 1'b0);
    check_value("beqz.fallthru", 32'(state_a), 32'd1);
    check_value("beqz.instret", 32'(instret_a), 32'd2);

    // Store: resume to FETCH (a) or back to INIT (b)
    rst_tick();
    for (int i = 0; i < 6; i++) go_tick(32'hA000_0000, 1'b0, 1'b0);
    check_value("store.resume", 32'(state_a), 32'd1);
    check_value("store.noresume", 32'(state_b), 32'd0);
    check_value("store.instret", 32'(instret_b), 32'd1);

    // Undefined opcode halts; reset clears instret
    rst_tick();
    for (int i = 0; i < 5; i++) go_tick(32'h0000_0020, 1'b0, 1'b0);
    go_tick(32'hFC00_0000, 1'b0, 1'b0);
    go_tick(32'hFC00_0000, 1'b0, 1'b0);
    check_value("undef.halt", 32'(state_a), 32'd19);
    check_value("undef.in_init", 32'(in_init_a), 32'd1);
    check_value("undef.instret", 32'(instret_a), 32'd1);
    rst_tick();
    check_value("undef.reset", 32'(state_a), 32'd0);
    check_value("undef.clr", 32'(instret_a), 32'd0);

    // Randomized run
    burst = 0;
    for (int i = 0; i < 4000; i++) begin
      logic r, b;
      r = ($urandom_range(0, 199) == 0) ||
          ((m_st[0] >= 19 || m_st[1] >= 19) && $urandom_range(0, 7) == 0);
      if (burst > 0) begin
        b = 1'b1;
        burst--;
      end else if ($urandom_range(0, 19) == 0) begin
        b = 1'b1;
        burst = $urandom_range(2, 17);
      end else begin
        b = ($urandom_range(0, 3) == 0);
      end
      tick(r, ($urandom_range(0, 3) == 0), ($urandom_range(0, 3) != 0), b,
           $urandom, $urandom_range(0, 1) == 1);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
